// File: rtl/control_sequencer.sv
// Timing and control unit of the basic accumulator CPU: sequence counter, indirect and run flags,
// decoding {S, SC, I, IR} into register-file strobes, bus select, ALU op and memory read/write.
module control_sequencer #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 16,
  parameter bit          RUN_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic              ac_zero,
  input  logic              ac_sign,
  input  logic              dr_zero,
  output logic              load_PC,
  output logic              load_AR,
  output logic              load_IR,
  output logic              load_DR,
  output logic              load_AC,
  output logic              increment_PC,
  output logic              increment_AR,
  output logic              increment_DR,
  output logic              increment_AC,
  output logic              clear_AC,
  output logic [2:0]        bus_sel,
  output logic [1:0]        alu_op,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              running,
  output logic [2:0]        sc
);

  localparam logic [2:0] BUS_AR  = 3'd1;
  localparam logic [2:0] BUS_PC  = 3'd2;
  localparam logic [2:0] BUS_DR  = 3'd3;
  localparam logic [2:0] BUS_AC  = 3'd4;
  localparam logic [2:0] BUS_IR  = 3'd5;
  localparam logic [2:0] BUS_MEM = 3'd7;

  logic [2:0] sc_q, sc_d;
  logic       i_q, i_d;
  logic       s_q, s_d;
  logic [2:0] op_d;
  logic       skip;
  logic       unused_ir;

  assign op_d      = ir[ADDR_W+2:ADDR_W];
  assign skip      = (ir[4] & ~ac_sign) | (ir[3] & ac_sign) | (ir[2] & ac_zero);
  assign unused_ir = ^{ir[10], ir[8:6], ir[1]};
  assign running   = s_q;
  assign sc        = sc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= 3'd0;
      i_q  <= 1'b0;
      s_q  <= RUN_ON_RESET;
    end else begin
      sc_q <= sc_d;
      i_q  <= i_d;
      s_q  <= s_d;
    end
  end

  // start is a level sampled only while idle; the first cycle after S rises is T0.
  always_comb begin
    sc_d = sc_q;
    i_d  = i_q;
    s_d  = s_q;
    if (!s_q) begin
      sc_d = 3'd0;
      if (start) s_d = 1'b1;
    end else begin
      sc_d = (sc_q == 3'd6) ? 3'd0 : sc_q + 3'd1;
      case (sc_q)
        3'd2: i_d = ir[DATA_W-1];
        3'd3: if (op_d == 3'd7) begin
          sc_d = 3'd0;
          if (!i_q && ir[0]) s_d = 1'b0;
        end
        3'd4: if (op_d == 3'd3 || op_d == 3'd4) sc_d = 3'd0;
        3'd5: if (op_d != 3'd6) sc_d = 3'd0;
        default: ;
      endcase
    end
  end

  always_comb begin
    load_PC      = 1'b0;
    load_AR      = 1'b0;
    load_IR      = 1'b0;
    load_DR      = 1'b0;
    load_AC      = 1'b0;
    increment_PC = 1'b0;
    increment_AR = 1'b0;
    increment_DR = 1'b0;
    increment_AC = 1'b0;
    clear_AC     = 1'b0;
    bus_sel      = 3'd0;
    alu_op       = 2'd0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    if (s_q) begin
      case (sc_q)
        3'd0: begin bus_sel = BUS_PC; load_AR = 1'b1; end
        3'd1: begin mem_rd = 1'b1; bus_sel = BUS_MEM; load_IR = 1'b1; increment_PC = 1'b1; end
        3'd2: begin bus_sel = BUS_IR; load_AR = 1'b1; end
        3'd3: begin
          if (op_d != 3'd7) begin
            if (i_q) begin mem_rd = 1'b1; bus_sel = BUS_MEM; load_AR = 1'b1; end
          end else if (!i_q) begin
            // Only one AC action per cycle: CLA wins over CMA, CMA over INC.
            if (ir[11])     clear_AC = 1'b1;
            else if (ir[9]) begin load_AC = 1'b1; alu_op = 2'd3; end
            else if (ir[5]) increment_AC = 1'b1;
            increment_PC = skip;
          end
        end
        3'd4: case (op_d)
          3'd0, 3'd1, 3'd2, 3'd6: begin mem_rd = 1'b1; bus_sel = BUS_MEM; load_DR = 1'b1; end
          3'd3: begin bus_sel = BUS_AC; mem_wr = 1'b1; end
          3'd4: begin bus_sel = BUS_AR; load_PC = 1'b1; end
          3'd5: begin bus_sel = BUS_PC; mem_wr = 1'b1; increment_AR = 1'b1; end
          default: ;
        endcase
        3'd5: case (op_d)
          3'd0: begin load_AC = 1'b1; alu_op = 2'd1; end
          3'd1: begin load_AC = 1'b1; alu_op = 2'd2; end
          3'd2: begin load_AC = 1'b1; alu_op = 2'd0; end
          3'd5: begin bus_sel = BUS_AR; load_PC = 1'b1; end
          3'd6: increment_DR = 1'b1;
          default: ;
        endcase
        3'd6: begin bus_sel = BUS_DR; mem_wr = 1'b1; increment_PC = dr_zero; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Closed-loop bench: a register file + memory environment follows the strobes, and an
// instruction-level CPU model predicts PC, AC, memory and cycle count for every instruction.
module tb_control_sequencer;

  logic        clk, rst_n, start;
  logic [15:0] ir;
  logic        ac_zero, ac_sign, dr_zero;
  logic        load_PC, load_AR, load_IR, load_DR, load_AC;
  logic        increment_PC, increment_AR, increment_DR, increment_AC, clear_AC;
  logic [2:0]  bus_sel, sc;
  logic [1:0]  alu_op;
  logic        mem_rd, mem_wr, running;
  logic [16:0] outs;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir),
    .ac_zero(ac_zero), .ac_sign(ac_sign), .dr_zero(dr_zero),
    .load_PC(load_PC), .load_AR(load_AR), .load_IR(load_IR), .load_DR(load_DR), .load_AC(load_AC),
    .increment_PC(increment_PC), .increment_AR(increment_AR), .increment_DR(increment_DR),
    .increment_AC(increment_AC), .clear_AC(clear_AC), .bus_sel(bus_sel), .alu_op(alu_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .running(running), .sc(sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Environment: register file and memory
  logic [11:0] pc_r, ar_r;
  logic [15:0] ir_r, dr_r, ac_r;
  logic [15:0] mem [4096];
  assign ir      = ir_r;
  assign ac_zero = (ac_r == 16'd0);
  assign ac_sign = ac_r[15];
  assign dr_zero = (dr_r == 16'd0);
  assign outs = {load_PC, load_AR, load_IR, load_DR, load_AC, increment_PC, increment_AR,
                 increment_DR, increment_AC, clear_AC, mem_rd, mem_wr, bus_sel, alu_op};

  // Instruction-level reference model
  logic [11:0] m_pc;
  logic [15:0] m_ac;
  logic [15:0] m_mem [4096];

  int n_chk = 0;
  int n_err = 0;
  logic [2:0]  t3_ac;
  logic [11:0] ar_t4;
  logic [1:0]  t6_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bus_val();
    case (bus_sel)
      3'd1:    return {4'd0, ar_r};
      3'd2:    return {4'd0, pc_r};
      3'd3:    return dr_r;
      3'd4:    return ac_r;
      3'd5:    return ir_r;
      3'd7:    return mem[ar_r];
      default: return 16'd0;
    endcase
  endfunction

  task automatic tick();
    logic [15:0] b, alu;
    @(posedge clk);
    b = bus_val();
    case (alu_op)
      2'd0:    alu = dr_r;
      2'd1:    alu = ac_r & dr_r;
      2'd2:    alu = ac_r + dr_r;
      default: alu = ~ac_r;
    endcase
    if (load_PC) pc_r <= b[11:0]; else if (increment_PC) pc_r <= pc_r + 12'd1;
    if (load_AR) ar_r <= b[11:0]; else if (increment_AR) ar_r <= ar_r + 12'd1;
    if (load_IR) ir_r <= b;
    if (load_DR) dr_r <= b; else if (increment_DR) dr_r <= dr_r + 16'd1;
    if (clear_AC) ac_r <= 16'd0;
    else if (load_AC) ac_r <= alu;
    else if (increment_AC) ac_r <= ac_r + 16'd1;
    if (mem_wr) mem[ar_r] <= b;
    #1;
  endtask

  task automatic inv();
    chk("ld_inc_excl", 32'({load_PC & increment_PC, load_AR & increment_AR,
                            load_DR & increment_DR, load_AC & increment_AC}), 32'd0);
    chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
    chk("ac_one_action", 32'($countones({clear_AC, load_AC, increment_AC}) <= 1), 32'd1);
    chk("sc_range", 32'(sc <= 3'd6), 32'd1);
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] v);
    mem[a] <= v;
    m_mem[a] = v;
  endtask

  task automatic setup(input logic [11:0] pc0, input logic [15:0] ac0);
    pc_r <= pc0; ac_r <= ac0; ar_r <= 12'd0; ir_r <= 16'd0; dr_r <= 16'd0;
    m_pc = pc0;  m_ac = ac0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("go_running", 32'(running), 32'd1);
  endtask

  // One instruction at ISA level: returns cycle count and whether it halts.
  task automatic model_step(output int cyc, output bit halt);
    logic [15:0] w, v, p;
    logic [11:0] ea;
    logic [2:0]  d;
    logic        sk;
    w = m_mem[m_pc];
    m_pc = m_pc + 12'd1;
    d = w[14:12];
    halt = 1'b0;
    cyc = 4;
    if (d == 3'd7) begin
      if (!w[15]) begin
        sk = (w[4] && !m_ac[15]) || (w[3] && m_ac[15]) || (w[2] && m_ac == 16'd0);
        if (w[11]) m_ac = 16'd0;
        else if (w[9]) m_ac = ~m_ac;
        else if (w[5]) m_ac = m_ac + 16'd1;
        if (sk) m_pc = m_pc + 12'd1;
        halt = w[0];
      end
    end else begin
      p = m_mem[w[11:0]];
      ea = w[15] ? p[11:0] : w[11:0];
      case (d)
        3'd0: begin m_ac = m_ac & m_mem[ea]; cyc = 6; end
        3'd1: begin m_ac = m_ac + m_mem[ea]; cyc = 6; end
        3'd2: begin m_ac = m_mem[ea]; cyc = 6; end
        3'd3: begin m_mem[ea] = m_ac; cyc = 5; end
        3'd4: begin m_pc = ea; cyc = 5; end
        3'd5: begin m_mem[ea] = {4'd0, m_pc}; m_pc = ea + 12'd1; cyc = 6; end
        default: begin
          v = m_mem[ea] + 16'd1;
          m_mem[ea] = v;
          if (v == 16'd0) m_pc = m_pc + 12'd1;
          cyc = 7;
        end
      endcase
    end
  endtask

  task automatic exec_instr();
    int exp_cyc, cnt, diffs;
    bit exp_halt;
    chk("t0_sc", 32'(sc), 32'd0);
    chk("t0_running", 32'(running), 32'd1);
    model_step(exp_cyc, exp_halt);
    cnt = 0;
    do begin
      if (sc == 3'd3) t3_ac = {clear_AC, load_AC, increment_AC};
      if (sc == 3'd4) ar_t4 = ar_r;
      if (sc == 3'd6) t6_wd = {mem_wr, dr_zero};
      tick();
      inv();
      cnt++;
    end while (!(sc == 3'd0 || !running) && cnt < 12);
    chk("cycles", 32'(cnt), 32'(exp_cyc));
    chk("pc", 32'(pc_r), 32'(m_pc));
    chk("ac", 32'(ac_r), 32'(m_ac));
    diffs = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== m_mem[a]) diffs++;
    chk("mem_diffs", 32'(diffs), 32'd0);
    chk("running_after", 32'(running), 32'(!exp_halt));
    if (exp_halt) begin
      repeat (3) begin
        tick();
        chk("halt_sc_hold", 32'(sc), 32'd0);
        chk("halt_quiet", 32'(outs), 32'd0);
      end
      go();
    end
  endtask

  initial begin
    int cnt;
    logic [15:0] w;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 4096; a++) poke(12'(a), 16'd0);
    setup(12'd0, 16'd0);
    #1;
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_sc", 32'(sc), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_sc", 32'(sc), 32'd0);
    chk("idle_running", 32'(running), 32'd0);

    // Reset in the middle of ADD's T5 abandons the instruction
    poke(12'h000, 16'h1005); poke(12'h005, 16'h0003); poke(12'h001, 16'h7001);
    setup(12'd0, 16'h0004);
    go();
    cnt = 0;
    while (sc != 3'd5 && cnt < 10) begin tick(); cnt++; end
    chk("reach_t5", 32'(sc), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs), 32'd0);
    chk("midrst_sc", 32'(sc), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    tick();
    chk("midrst_ac_kept", 32'(ac_r), 32'h0004);
    rst_n = 1'b1;
    go();
    chk("midrst_t0", 32'(sc), 32'd0);
    chk("midrst_pc", 32'(pc_r), 32'd1);
    m_pc = pc_r; m_ac = ac_r;
    exec_instr();
    hard_reset();

    // LDA 5
    poke(12'h000, 16'h2005); poke(12'h005, 16'h1234);
    setup(12'd0, 16'hBEEF);
    go(); exec_instr();
    chk("lda_ac", 32'(ac_r), 32'h1234);
    chk("lda_pc", 32'(pc_r), 32'h001);
    hard_reset();

    // ADD indirect through M[6]
    poke(12'h000, 16'h9006); poke(12'h006, 16'h0010); poke(12'h010, 16'h0003);
    setup(12'd0, 16'h0004);
    go(); exec_instr();
    chk("addi_ar_t4", 32'(ar_t4), 32'h010);
    chk("addi_ac", 32'(ac_r), 32'h0007);
    hard_reset();

    // ISZ wrapping to zero skips
    poke(12'h000, 16'h6020); poke(12'h020, 16'hFFFF);
    setup(12'd0, 16'h0000);
    go(); exec_instr();
    chk("isz_mem", 32'(mem[12'h020]), 32'h0000);
    chk("isz_t6", 32'(t6_wd), 32'b11);
    chk("isz_pc", 32'(pc_r), 32'h002);
    hard_reset();

    // BSA 8
    poke(12'h000, 16'h5008);
    setup(12'd0, 16'h0000);
    go(); exec_instr();
    chk("bsa_mem", 32'(mem[12'h008]), 32'h0001);
    chk("bsa_pc", 32'(pc_r), 32'h009);
    hard_reset();

    // CLA|CMA|INC|HLT: only CLA acts, then halt
    poke(12'h000, 16'h7A21);
    setup(12'd0, 16'h1234);
    go(); exec_instr();
    chk("cla_only", 32'(t3_ac), 32'b100);
    hard_reset();

    // Random programs
    for (int p = 0; p < 6; p++) begin
      for (int a = 0; a < 4096; a++) begin
        w = 16'($urandom);
        k = $urandom_range(0, 9);
        if (k < 2) w = 16'hFFFF;
        else if (k == 2) w = {4'h7, w[11:1], 1'($urandom_range(0, 7) == 0)};
        poke(12'(a), w);
      end
      setup(12'($urandom), 16'($urandom));
      go();
      repeat (50) exec_instr();
      hard_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
